// File: rtl/arb_req_queue_if.sv
// arb_req_queue_if: handshake bundle between requester sources, arbiter and output sink
//   in_valid/in_data/in_ready : per-port push channel, port i at in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   req/grant                 : queue-occupancy requests out, one-hot grants in
//   out_valid/out_data/out_src: popped beat, no backpressure
//   err                       : sticky protocol-error flag
interface arb_req_queue_if #(
   parameter int NUM_REQUESTS = 4,
   parameter int DATA_WIDTH   = 32
);
   localparam int SW = NUM_REQUESTS > 1 ? $clog2(NUM_REQUESTS) : 1;
   logic [NUM_REQUESTS-1:0]            in_valid;
   logic [NUM_REQUESTS*DATA_WIDTH-1:0] in_data;
   logic [NUM_REQUESTS-1:0]            in_ready;
   logic [NUM_REQUESTS-1:0]            req;
   logic [NUM_REQUESTS-1:0]            grant;
   logic                               out_valid;
   logic [DATA_WIDTH-1:0]              out_data;
   logic [SW-1:0]                      out_src;
   logic                               err;
   modport master (
      output in_valid, in_data, grant,
      input  in_ready, req, out_valid, out_data, out_src, err
   );
   modport slave (
      input  in_valid, in_data, grant,
      output in_ready, req, out_valid, out_data, out_src, err
   );
endinterface

// File: rtl/arb_req_queue.sv
// arb_req_queue: per-requester FIFOs feeding a round-robin arbiter, draining granted queue onto one bus
//   clk, reset : clock and synchronous active-high reset
//   bus        : arb_req_queue_if slave (push channels, req/grant, output beat, err)
module arb_req_queue #(
   parameter int NUM_REQUESTS = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 4
) (
   input logic             clk,
   input logic             reset,
   arb_req_queue_if.slave  bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = NUM_REQUESTS > 1 ? $clog2(NUM_REQUESTS) : 1;
   logic [DATA_WIDTH-1:0] mem_q [NUM_REQUESTS][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [NUM_REQUESTS][FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q [NUM_REQUESTS], wr_ptr_d [NUM_REQUESTS];
   logic [PW-1:0]         rd_ptr_q [NUM_REQUESTS], rd_ptr_d [NUM_REQUESTS];
   logic [CW-1:0]         cnt_q [NUM_REQUESTS], cnt_d [NUM_REQUESTS];
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SW-1:0]         out_src_q, out_src_d;
   logic                  err_q, err_d;
   logic [NUM_REQUESTS-1:0] push, pop;
   logic                    one_hot;
   assign one_hot = $onehot(bus.grant);
   assign push    = bus.in_valid & bus.in_ready;
   // a pop needs a clean one-hot grant onto a non-empty queue
   assign pop     = bus.grant & bus.req & {NUM_REQUESTS{one_hot}};
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.err       = err_q;
   always_comb begin
      bus.in_ready = '0;
      bus.req      = '0;
      for (int i = 0; i < NUM_REQUESTS; i++) begin
         bus.in_ready[i] = !reset && (cnt_q[i] != CW'(FIFO_DEPTH));
         bus.req[i]      = cnt_q[i] != '0;
      end
   end
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      // grant to an empty queue or a multi-bit grant is a protocol violation
      err_d       = err_q | (|(bus.grant & ~bus.req)) | ((|bus.grant) && !one_hot);
      for (int i = 0; i < NUM_REQUESTS; i++) begin
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
         end
         if (pop[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = mem_q[i][rd_ptr_q[i]];
            out_src_d   = SW'(i);
         end
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         for (int i = 0; i < NUM_REQUESTS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_arb_req_queue.sv
// tb_arb_req_queue: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_arb_req_queue;
   localparam int N = 4;
   localparam int W = 32;
   localparam int D = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   arb_req_queue_if #(.NUM_REQUESTS(N), .DATA_WIDTH(W)) bus ();
   arb_req_queue #(.NUM_REQUESTS(N), .DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   int tests = 0;
   int fails = 0;
   logic [W-1:0] q [N][$];
   logic         m_ov  = 1'b0;
   logic [W-1:0] m_od  = '0;
   logic [1:0]   m_os  = '0;
   logic         m_err = 1'b0;
   typedef struct {
      logic         rst;
      logic [N-1:0] iv;
      logic [W-1:0] d0;
      logic [N-1:0] gr;
      logic [N-1:0] req;
      logic [N-1:0] rdy;
      logic         ov;
      logic [W-1:0] od;
      logic         err;
   } vec_t;
   vec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] pk(input int p, input logic [W-1:0] d);
      logic [N*W-1:0] v;
      v = '0;
      v[p*W +: W] = d;
      return v;
   endfunction

   task automatic model(input logic r, input logic [N-1:0] iv, input logic [N*W-1:0] id, input logic [N-1:0] gr);
      bit [N-1:0] full;
      if (r) begin
         for (int i = 0; i < N; i++) q[i].delete();
         m_ov = 0; m_od = '0; m_os = '0; m_err = 0;
      end else begin
         for (int i = 0; i < N; i++) full[i] = q[i].size() == D;
         m_ov = 0;
         for (int i = 0; i < N; i++)
            if (gr[i] && (q[i].size() == 0 || $countones(gr) > 1)) m_err = 1;
         if ($countones(gr) == 1)
            for (int i = 0; i < N; i++)
               if (gr[i] && q[i].size() > 0) begin
                  m_od = q[i].pop_front();
                  m_os = 2'(i);
                  m_ov = 1;
               end
         for (int i = 0; i < N; i++)
            if (iv[i] && !full[i]) q[i].push_back(id[i*W +: W]);
      end
   endtask

   task automatic compare_model();
      logic [N-1:0] er, ey;
      for (int i = 0; i < N; i++) begin
         er[i] = q[i].size() != 0;
         ey[i] = !reset && q[i].size() < D;
      end
      check("req", 32'(bus.req), 32'(er));
      check("in_ready", 32'(bus.in_ready), 32'(ey));
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("out_data", bus.out_data, m_od);
      check("out_src", 32'(bus.out_src), 32'(m_os));
      check("err", 32'(bus.err), 32'(m_err));
   endtask

   task automatic step(input logic r, input logic [N-1:0] iv, input logic [N*W-1:0] id, input logic [N-1:0] gr);
      @(negedge clk);
      reset = r;
      bus.in_valid = iv;
      bus.in_data = id;
      bus.grant = gr;
      @(posedge clk);
      model(r, iv, id, gr);
      #1;
      compare_model();
   endtask

   initial begin
      bus.in_valid = '0;
      bus.in_data = '0;
      bus.grant = '0;
      // reset, fill port 0 past full, drain it with four grants
      tbl.push_back('{1, 4'b0000, 32'h00, 4'b0000, 4'b0000, 4'b0000, 0, 32'h00, 0});
      tbl.push_back('{1, 4'b0000, 32'h00, 4'b0000, 4'b0000, 4'b0000, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 4'b1111, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0001, 32'hA0, 4'b0000, 4'b0001, 4'b1111, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0001, 32'hA1, 4'b0000, 4'b0001, 4'b1111, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0001, 32'hA2, 4'b0000, 4'b0001, 4'b1111, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0001, 32'hA3, 4'b0000, 4'b0001, 4'b1110, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0001, 32'hA4, 4'b0000, 4'b0001, 4'b1110, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0000, 4'b0001, 4'b1110, 0, 32'h00, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0001, 4'b0001, 4'b1111, 1, 32'hA0, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0001, 4'b0001, 4'b1111, 1, 32'hA1, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0001, 4'b0001, 4'b1111, 1, 32'hA2, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0001, 4'b0000, 4'b1111, 1, 32'hA3, 0});
      tbl.push_back('{0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 4'b1111, 0, 32'hA3, 0});
      foreach (tbl[k]) begin
         step(tbl[k].rst, tbl[k].iv, pk(0, tbl[k].d0), tbl[k].gr);
         check("tbl_req", 32'(bus.req), 32'(tbl[k].req));
         check("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[k].rdy));
         check("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[k].ov));
         check("tbl_out_data", bus.out_data, tbl[k].od);
         check("tbl_err", 32'(bus.err), 32'(tbl[k].err));
      end
      // simultaneous push and pop on port 2 keeps occupancy and FIFO order
      step(0, 4'b0100, pk(2, 32'hC0), 4'b0000);
      step(0, 4'b0100, pk(2, 32'hC1), 4'b0000);
      step(0, 4'b0100, pk(2, 32'hC2), 4'b0100);
      check("pushpop_data", bus.out_data, 32'hC0);
      check("pushpop_src", 32'(bus.out_src), 32'd2);
      step(0, 4'b0000, '0, 4'b0100);
      check("pushpop_c1", bus.out_data, 32'hC1);
      step(0, 4'b0000, '0, 4'b0100);
      check("pushpop_c2", bus.out_data, 32'hC2);
      check("pushpop_req_drop", 32'(bus.req), 32'd0);
      // grant to empty queue sets sticky err
      step(0, 4'b0000, '0, 4'b0010);
      check("err_empty_ov", 32'(bus.out_valid), 32'd0);
      check("err_empty", 32'(bus.err), 32'd1);
      step(0, 4'b0000, '0, 4'b0000);
      check("err_sticky", 32'(bus.err), 32'd1);
      // multi-bit grant: error and no pop
      step(1, '0, '0, '0);
      step(1, '0, '0, '0);
      check("err_cleared", 32'(bus.err), 32'd0);
      step(0, 4'b0011, pk(0, 32'hD0) | pk(1, 32'hD1), 4'b0000);
      step(0, 4'b0000, '0, 4'b0011);
      check("multi_err", 32'(bus.err), 32'd1);
      check("multi_ov", 32'(bus.out_valid), 32'd0);
      check("multi_req", 32'(bus.req), 32'b0011);
      step(0, 4'b0000, '0, 4'b0001);
      check("multi_after_d0", bus.out_data, 32'hD0);
      step(0, 4'b0000, '0, 4'b0010);
      check("multi_after_d1", bus.out_data, 32'hD1);
      // reset during a drain flushes the queue
      step(1, '0, '0, '0);
      for (int i = 0; i < 4; i++) step(0, 4'b0001, pk(0, 32'hB0 + 32'(i)), 4'b0000);
      step(0, 4'b0000, '0, 4'b0001);
      step(0, 4'b0000, '0, 4'b0001);
      check("drain_b1", bus.out_data, 32'hB1);
      step(1, 4'b0000, '0, 4'b0001);
      check("midrst_ov", 32'(bus.out_valid), 32'd0);
      check("midrst_req", 32'(bus.req), 32'd0);
      step(0, 4'b0000, '0, 4'b0000);
      check("midrst_empty", 32'(bus.req), 32'd0);
      step(0, 4'b0001, pk(0, 32'hB9), 4'b0000);
      step(0, 4'b0000, '0, 4'b0001);
      check("midrst_fresh", bus.out_data, 32'hB9);
      // randomized traffic against the model
      step(1, '0, '0, '0);
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] g;
         logic [N*W-1:0] d;
         int k;
         int ne [$];
         for (int i = 0; i < N; i++) begin
            d[i*W +: W] = $urandom;
            if (q[i].size() != 0) ne.push_back(i);
         end
         k = $urandom_range(0, 19);
         g = '0;
         if (k < 14) begin
            if (ne.size() != 0) g[ne[$urandom_range(0, ne.size() - 1)]] = 1'b1;
         end else if (k < 17) g = '0;
         else if (k < 19) g[$urandom_range(0, N - 1)] = 1'b1;
         else g = 4'($urandom);
         step($urandom_range(0, 49) == 0, 4'($urandom), d, g);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
